spi_master_clkgen: RTL and testbench

- Generates the SPI serial clock and one-cycle edge strobes for the SPI master datapath from the system clock.
- Sits directly upstream of the RX and TX shifters: they request clocking via their clock-enable outputs (ORed into en), and sample or shift on spi_rise / spi_fall.
- Provides a programmable divider, CPOL idle level, clean stop at idle level, and glitch-free divider updates mid-transfer.

---
 rtl/spi_master_clkgen.sv | 167 ++++++++++++++++
 tb/tb_spi_master_clkgen.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_clkgen.sv
// spi_master_clkgen
//   Generates the SPI serial clock and one-cycle edge strobes for the SPI
//   master shifters. The serial clock is a registered copy of a half-period
//   counter toggle; spi_rise / spi_fall announce the toggle one cycle early so
//   the RX/TX shifters can act on the same edge that spi_clk changes.
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   en            clock request (OR of shifter clock enables), level-sensitive
//   cpol          idle level of spi_clk, sampled only while idle
//   clk_div       half period minus one, in clk cycles
//   clk_div_valid one-cycle strobe that loads clk_div
//   spi_clk       registered serial clock
//   spi_rise      high in the cycle before spi_clk goes 0->1
//   spi_fall      high in the cycle before spi_clk goes 1->0
//   running       high while the clock is active or winding down
module spi_master_clkgen #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cpol,
  input  logic [CNT_W-1:0] clk_div,
  input  logic             clk_div_valid,
  output logic             spi_clk,
  output logic             spi_rise,
  output logic             spi_fall,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend_div;
  logic             pend_flag;
  logic             cpol_reg;
  // High for the first RUN cycle: holds the counter one extra cycle so the
  // first toggle lands div_reg+2 edges after the start request.
  logic             lead;

  logic             suppress;
  logic             pulse;
  logic             returning;
  logic             apply_pend;

  // ---------------------------------------------------------------------
  // Strobe generation and next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    suppress   = 1'b0;
    pulse      = 1'b0;
    returning  = 1'b0;
    apply_pend = 1'b0;
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;

    // Clock already at idle level and no longer requested: stop right here
    // rather than emitting an edge that would leave the idle level.
    suppress  = (state == RUN) && !en && (spi_clk == cpol_reg);
    pulse     = (state != IDLE) && !lead && (cnt == div_reg) && !suppress;
    // A toggle that brings spi_clk back to its idle level closes a full
    // period; this is the only safe point to change the divider.
    returning = pulse && (spi_clk != cpol_reg);

    unique case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          if (suppress || returning) state_nxt = IDLE;
          else                       state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        if (en)             state_nxt = RUN;
        else if (returning) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    apply_pend = (state != IDLE) && (returning || (state_nxt == IDLE));

    if ((state == IDLE) || (state_nxt == IDLE) || lead || pulse) begin
      cnt_nxt = '0;
    end
  end

  assign spi_rise = pulse & ~spi_clk;
  assign spi_fall = pulse &  spi_clk;
  assign running  = (state != IDLE);

  // ---------------------------------------------------------------------
  // State, counter and start-up hold
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      lead  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lead  <= (state == IDLE) && en;
    end
  end

  // ---------------------------------------------------------------------
  // Serial clock and captured polarity
  // ---------------------------------------------------------------------
  // While idle both registers follow cpol together, so spi_clk always equals
  // cpol_reg when a transfer starts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_clk  <= 1'b0;
      cpol_reg <= 1'b0;
    end else if (state == IDLE) begin
      spi_clk  <= cpol;
      cpol_reg <= cpol;
    end else if (pulse) begin
      spi_clk  <= ~spi_clk;
    end
  end

  // ---------------------------------------------------------------------
  // Divider register with deferred update while running
  // ---------------------------------------------------------------------
  // A write landing on the same edge as an apply point goes to pending while
  // the previous pending value is committed, so nothing is lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_reg   <= CNT_W'(DIV_RESET);
      pend_div  <= '0;
      pend_flag <= 1'b0;
    end else if (state == IDLE) begin
      if (clk_div_valid) begin
        div_reg   <= clk_div;
        pend_flag <= 1'b0;
      end else if (pend_flag) begin
        div_reg   <= pend_div;
        pend_flag <= 1'b0;
      end
    end else begin
      if (apply_pend && pend_flag) begin
        div_reg <= pend_div;
      end
      if (clk_div_valid) begin
        pend_div  <= clk_div;
        pend_flag <= 1'b1;
      end else if (apply_pend) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_clkgen.sv
module tb_spi_master_clkgen;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       cpol;
  logic [7:0] clk_div;
  logic       clk_div_valid;
  logic       spi_clk;
  logic       spi_rise;
  logic       spi_fall;
  logic       running;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  spi_master_clkgen #(.CNT_W(8), .DIV_RESET(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .cpol          (cpol),
    .clk_div       (clk_div),
    .clk_div_valid (clk_div_valid),
    .spi_clk       (spi_clk),
    .spi_rise      (spi_rise),
    .spi_fall      (spi_fall),
    .running       (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: countdown to the next toggle, expressed in edges.
  bit m_active, m_stop, m_level, m_cpol, m_pflag;
  int m_rem, m_div, m_pdiv;

  function automatic void model_reset();
    m_active = 0; m_stop = 0; m_level = 0; m_cpol = 0;
    m_pflag = 0; m_rem = 0; m_div = 4; m_pdiv = 0;
  endfunction

  function automatic bit model_tog();
    bit supp;
    supp = !m_stop && !en && (m_level == m_cpol);
    return m_active && (m_rem == 1) && !supp;
  endfunction

  function automatic logic [3:0] expv();
    bit t;
    t = model_tog();
    return {m_level, t & ~m_level, t & m_level, m_active};
  endfunction

  function automatic void model_edge();
    bit t, supp, ret, goidle, apply;
    if (!m_active) begin
      m_cpol  = cpol;
      m_level = cpol;
      if (clk_div_valid) begin m_div = int'(clk_div); m_pflag = 0; end
      else if (m_pflag) begin m_div = m_pdiv; m_pflag = 0; end
      if (en) begin m_active = 1; m_stop = 0; m_rem = m_div + 2; end
    end else begin
      t      = model_tog();
      supp   = !m_stop && !en && (m_level == m_cpol);
      ret    = t && (m_level != m_cpol);
      goidle = supp || (!en && ret);
      apply  = ret || goidle;
      if (apply && m_pflag) m_div = m_pdiv;
      if (clk_div_valid) begin m_pdiv = int'(clk_div); m_pflag = 1; end
      else if (apply) m_pflag = 0;
      if (t) begin m_level = !m_level; m_rem = m_div + 1; end
      else m_rem = m_rem - 1;
      if (goidle) begin m_active = 0; m_stop = 0; end
      else m_stop = !en;
    end
  endfunction

  // One active edge; inputs are changed by callers 1ns after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; cpol = 1'b0; clk_div = '0; clk_div_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; cpol = 1'b0; clk_div = '0; clk_div_valid = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({spi_clk, spi_rise, spi_fall, running} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0000", {spi_clk, spi_rise, spi_fall, running});
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({spi_clk, spi_rise, spi_fall, running} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b want 0000", {spi_clk, spi_rise, spi_fall, running});
    end
    tick();
  endtask

  task automatic test_basic();
    int first_rise, second_rise;
    logic pre;
    first_rise = -1; second_rise = -1;
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL basic cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (spi_clk && !pre) begin
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
    end
    checks++;
    if (first_rise != 6) begin
      errors++; $display("FAIL basic_first_rise: got %0d want 6", first_rise);
    end
    checks++;
    if (second_rise - first_rise != 10) begin
      errors++; $display("FAIL basic_period: got %0d want 10", second_rise - first_rise);
    end
    en = 1'b0;
    for (int k = 0; k < 40 && running; k++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL basic_stop: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL basic_idle_timeout: running %b want 0", running);
    end
  endtask

  task automatic test_div0();
    int nfall;
    clk_div = 8'd0; clk_div_valid = 1'b1;
    tick();
    clk_div_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL div0 cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
      if (i > 4 && spi_clk) break;
    end
    checks++;
    if (spi_clk !== 1'b1) begin
      errors++; $display("FAIL div0_high_timeout: spi_clk %b want 1", spi_clk);
    end
    en = 1'b0;
    nfall = 0;
    for (int k = 0; k < 10 && running; k++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL div0_stop: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      if (spi_fall) nfall++;
      tick();
    end
    checks++;
    if (nfall != 1 || spi_clk !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL div0_final: falls %0d clk %b run %b want 1 0 0", nfall, spi_clk, running);
    end
  endtask

  task automatic test_cpol1();
    int first_t, last_t, fell, lastchg;
    logic pre_clk, pre_run;
    first_t = -1; last_t = -1; fell = -1; lastchg = -2;
    cpol = 1'b1; clk_div = 8'd2; clk_div_valid = 1'b1;
    tick();
    clk_div_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 7) en = 1'b0;
      if (i > 7 && !running) break;
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL cpol1 cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      if (spi_rise || spi_fall) begin
        if (first_t < 0) first_t = spi_fall;
        last_t = spi_fall;
      end
      pre_clk = spi_clk; pre_run = running;
      tick();
      if (pre_run && !running) fell = cyc;
      if (pre_clk != spi_clk) lastchg = cyc;
    end
    checks++;
    if (first_t != 1) begin
      errors++; $display("FAIL cpol1_first_fall: got fall=%0d want 1", first_t);
    end
    checks++;
    if (last_t != 0 || spi_clk !== 1'b1) begin
      errors++; $display("FAIL cpol1_end_rise: got fall=%0d clk %b want 0 1", last_t, spi_clk);
    end
    checks++;
    if (fell != lastchg) begin
      errors++; $display("FAIL cpol1_running_edge: got %0d want %0d", fell, lastchg);
    end
    cpol = 1'b0;
    tick();
  endtask

  task automatic test_div_update();
    int r, tg[$];
    logic pre;
    r = -1;
    clk_div = 8'd3; clk_div_valid = 1'b1;
    tick();
    clk_div_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL divupd_start: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (spi_clk && !pre) r = cyc;
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin clk_div = 8'd1; clk_div_valid = 1'b1; end
      else clk_div_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL divupd cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (pre != spi_clk) tg.push_back(cyc);
    end
    checks++;
    if (tg.size() < 3 || tg[0] - r != 4 || tg[1] - tg[0] != 2 || tg[2] - tg[1] != 2) begin
      errors++;
      $display("FAIL divupd_halves: got %0d toggles first %0d want 4,2,2", tg.size(),
               (tg.size() > 0) ? tg[0] - r : -1);
    end
    en = 1'b0;
    for (int k = 0; k < 20 && running; k++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL divupd_stop: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL divupd_idle_timeout: running %b want 0", running);
    end
  endtask

  task automatic test_en_glitch();
    int r, tg[$];
    bit ok;
    logic pre;
    r = -1;
    clk_div = 8'd3; clk_div_valid = 1'b1;
    tick();
    clk_div_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL glitch_start: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (spi_clk && !pre) r = cyc;
    end
    tg.push_back(r);
    for (int i = 0; i < 20; i++) begin
      en = (i == 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL glitch cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (pre != spi_clk) tg.push_back(cyc);
    end
    ok = (tg.size() >= 5);
    for (int j = 1; j < tg.size(); j++) if (tg[j] - tg[j-1] != 4) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL glitch_period: %0d toggles, spacing not uniform 4", tg.size());
    end
    en = 1'b0;
    for (int k = 0; k < 20 && running; k++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL glitch_stop: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) en = ~en;
      if ($urandom_range(0, 15) == 0) cpol = ~cpol;
      clk_div_valid = ($urandom_range(0, 9) == 0);
      clk_div = 8'($urandom_range(0, 5));
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
    end
    en = 1'b0; clk_div_valid = 1'b0;
    for (int k = 0; k < 40 && running; k++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL random_stop: got %b want %b", {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      tick();
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL random_idle_timeout: running %b want 0", running);
    end
  endtask

  task automatic test_async_reset();
    int first_rise;
    logic pre;
    first_rise = -1;
    clk_div = 8'd6; clk_div_valid = 1'b1;
    tick();
    clk_div_valid = 1'b0; cpol = 1'b0; en = 1'b1;
    for (int i = 0; i < 30 && !spi_clk; i++) tick();
    tick();
    checks++;
    if (spi_clk !== 1'b1 || running !== 1'b1) begin
      errors++; $display("FAIL areset_pre: clk %b run %b want 1 1", spi_clk, running);
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({spi_clk, spi_rise, spi_fall, running} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: got %b want 0000", {spi_clk, spi_rise, spi_fall, running});
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({spi_clk, spi_rise, spi_fall, running} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_idle: got %b want 0000", {spi_clk, spi_rise, spi_fall, running});
    end
    tick();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({spi_clk, spi_rise, spi_fall, running} !== expv()) begin
        errors++;
        $display("FAIL areset_after cyc %0d: got %b want %b", i, {spi_clk, spi_rise, spi_fall, running}, expv());
      end
      pre = spi_clk;
      tick();
      if (spi_clk && !pre && first_rise < 0) first_rise = i;
    end
    checks++;
    if (first_rise != 6) begin
      errors++; $display("FAIL areset_div_reset: first rise %0d want 6", first_rise);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_cpol1();
    test_div_update();
    test_en_glitch();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
